// File: rtl/ext_irq_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ext_irq_arbiter_pkg
//   Shared types and constants for the external-interrupt arbiter.
//   - state_e     : arbiter FSM states (IDLE, REQ, HOLD)
//   - IRQ_NUM_MAX : highest legal NUM_IRQ (the controller adds 4 to the
//                   6-bit number, so 60 lines is the ceiling)
//   - CNT_W       : width of the hold-off counter (HOLDOFF_CYCLES <= 15)
//   - NUM_W       : width of the granted line number
// ---------------------------------------------------------------------------
package ext_irq_arbiter_pkg;

  localparam int IRQ_NUM_MAX = 60;
  localparam int CNT_W       = 4;
  localparam int NUM_W       = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/irq_priority_encoder.sv
// ---------------------------------------------------------------------------
// irq_priority_encoder
//   Combinational find-first-set; the lowest set index wins.
//   Ports:
//     req_i   [WIDTH-1:0]  request vector
//     num_o   [5:0]        index of the lowest set bit (0 when none)
//     found_o              at least one bit is set
// ---------------------------------------------------------------------------
module irq_priority_encoder
  import ext_irq_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [NUM_W-1:0] num_o,
  output logic             found_o
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    num_o   = '0;
    found_o = 1'b0;
    // Scan from the top down so the last hit written is the lowest index.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i < IRQ_NUM_MAX && req_i[i]) begin
        num_o   = NUM_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ext_irq_arbiter.sv
// ---------------------------------------------------------------------------
// ext_irq_arbiter
//   Collects NUM_IRQ device request lines (per-line enable, edge/level mode)
//   into pending bits, grants the lowest pending index to the interrupt
//   controller with a hold-until-ack handshake, and waits HOLDOFF_CYCLES
//   after each ack before the next grant so level sources can be cleared.
//
//   Parameters: NUM_IRQ (1..60), HOLDOFF_CYCLES (1..15)
//   Optional:   `define MIST32_EXT_IRQ_INPUT_SYNC_EN puts a two-flop
//               synchroniser on iIRQ_LINE (+2 cycles line-to-pend latency).
//
//   Ports:
//     iCLOCK          system clock
//     inRESET         asynchronous active-low reset
//     iRESET_SYNC     synchronous reset, same effect as inRESET
//     iIRQ_LINE       device request lines, active high
//     iIRQ_ENABLE     per-line enable
//     iIRQ_EDGE_MODE  per-line mode: 1 = rising edge latched, 0 = level
//     oEXT_ACTIVE     request valid to the interrupt controller
//     oEXT_NUM        index of the granted line (holds last value)
//     iEXT_ACK        single-cycle acknowledge from the controller
//     oPENDING        current pending vector
// ---------------------------------------------------------------------------
module ext_irq_arbiter
  import ext_irq_arbiter_pkg::*;
#(
  parameter int NUM_IRQ        = 32,
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iRESET_SYNC,
  input  logic [NUM_IRQ-1:0] iIRQ_LINE,
  input  logic [NUM_IRQ-1:0] iIRQ_ENABLE,
  input  logic [NUM_IRQ-1:0] iIRQ_EDGE_MODE,
  output logic               oEXT_ACTIVE,
  output logic [NUM_W-1:0]   oEXT_NUM,
  input  logic               iEXT_ACK,
  output logic [NUM_IRQ-1:0] oPENDING
);

  logic [NUM_IRQ-1:0] line_v;
  logic [NUM_IRQ-1:0] line_prev_q;
  logic [NUM_IRQ-1:0] edge_pend_q, edge_pend_d;
  logic [NUM_IRQ-1:0] edge_set, ack_clr, level_pend, pend;
  state_e             state_q, state_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_W-1:0]   enc_num;
  logic               enc_found;
  logic               ack_req;

`ifdef MIST32_EXT_IRQ_INPUT_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else if (iRESET_SYNC) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= iIRQ_LINE;
      sync2_q <= sync1_q;
    end
  end

  assign line_v = sync2_q;
`else
  assign line_v = iIRQ_LINE;
`endif

  assign ack_req = (state_q == REQ) && iEXT_ACK;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_clr[i] = ack_req && (num_q == NUM_W'(i));
    end
  end

  // A new edge in the ack cycle wins over the clear, so it is not lost.
  // Dropping the enable discards a latched edge.
  assign edge_set    = line_v & ~line_prev_q & iIRQ_ENABLE & iIRQ_EDGE_MODE;
  assign edge_pend_d = edge_set | (edge_pend_q & ~ack_clr & iIRQ_ENABLE);
  assign level_pend  = line_v & iIRQ_ENABLE & ~iIRQ_EDGE_MODE;
  assign pend        = (edge_pend_q & iIRQ_EDGE_MODE) | level_pend;
  assign oPENDING    = pend;
  assign oEXT_NUM    = num_q;

  irq_priority_encoder #(
    .WIDTH (NUM_IRQ)
  ) u_enc (
    .req_i   (pend),
    .num_o   (enc_num),
    .found_o (enc_found)
  );

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    cnt_d       = cnt_q;
    oEXT_ACTIVE = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enc_found) begin
          num_d   = enc_num;
          state_d = REQ;
        end
      end
      REQ: begin
        // Drop in the ack cycle so the controller cannot relatch a duplicate.
        oEXT_ACTIVE = !iEXT_ACK;
        if (iEXT_ACK) begin
          cnt_d   = CNT_W'(HOLDOFF_CYCLES);
          state_d = HOLD;
        end
      end
      HOLD: begin
        cnt_d = cnt_q - CNT_W'(1);
        // The last hold-off cycle doubles as the arbitration cycle, so a
        // still-pending source is re-granted HOLDOFF_CYCLES+1 after the ack.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (enc_found) begin
            num_d   = enc_num;
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q     <= IDLE;
      num_q       <= '0;
      cnt_q       <= '0;
      edge_pend_q <= '0;
      line_prev_q <= '1;
    end else if (iRESET_SYNC) begin
      state_q     <= IDLE;
      num_q       <= '0;
      cnt_q       <= '0;
      edge_pend_q <= '0;
      line_prev_q <= '1;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      cnt_q       <= cnt_d;
      edge_pend_q <= edge_pend_d;
      line_prev_q <= line_v;
    end
  end

endmodule

// File: tb/tb_ext_irq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ext_irq_arbiter
//   Directed bench for ext_irq_arbiter (default build, NUM_IRQ = 32,
//   HOLDOFF_CYCLES = 2). Expected grants (number and latency) are queued
//   when stimulus is driven and compared when oEXT_ACTIVE rises.
// ---------------------------------------------------------------------------
module tb_ext_irq_arbiter;

  localparam int N  = 32;
  localparam int HO = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sync_rst;
  logic [N-1:0]  line, en, mode;
  logic          ack;
  logic          active;
  logic [5:0]    num;
  logic [N-1:0]  pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0] num;
    int         lat;
  } grant_t;

  grant_t exp_q[$];

  always #5 clk = ~clk;

  ext_irq_arbiter #(
    .NUM_IRQ        (N),
    .HOLDOFF_CYCLES (HO)
  ) dut (
    .iCLOCK         (clk),
    .inRESET        (rst_n),
    .iRESET_SYNC    (sync_rst),
    .iIRQ_LINE      (line),
    .iIRQ_ENABLE    (en),
    .iIRQ_EDGE_MODE (mode),
    .oEXT_ACTIVE    (active),
    .oEXT_NUM       (num),
    .iEXT_ACK       (ack),
    .oPENDING       (pending)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input logic [5:0] n, input int lat);
    grant_t g;
    g.num = n;
    g.lat = lat;
    exp_q.push_back(g);
  endtask

  // Wait (bounded) for oEXT_ACTIVE and compare against the oldest expectation.
  task automatic wait_grant(input string tag);
    grant_t g;
    int     n = 0;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_nonempty"}, 64'(exp_q.size()), 64'd1);
      return;
    end
    g = exp_q.pop_front();
    while (!active && n < 20) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(g.lat));
    check({tag, "_num"}, 64'(num), 64'(g.num));
  endtask

  // Single-cycle ack; ACTIVE must fall combinationally in the ack cycle.
  task automatic do_ack(input string tag);
    ack = 1'b1;
    #1;
    check({tag, "_ack_drop"}, 64'(active), 64'd0);
    step();
    ack = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    sync_rst = 1'b0;
    ack      = 1'b0;
    line     = '0;
    en       = '1;
    mode     = '1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_active",  64'(active),  64'd0);
    check("reset_num",     64'(num),     64'd0);
    check("reset_pending", 64'(pending), 64'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // Edge line 3, single-cycle pulse.
    line[3] = 1'b1;
    step();
    line[3] = 1'b0;
    check("t1_pend3", 64'(pending[3]), 64'd1);
    expect_grant(6'd3, 1);
    wait_grant("t1");
    do_ack("t1");
    check("t1_pend3_cleared", 64'(pending[3]), 64'd0);
    repeat (3) step();

    // Edge lines 5 and 2 together: 2 first, 5 after the hold-off.
    line[5] = 1'b1;
    line[2] = 1'b1;
    step();
    line[5] = 1'b0;
    line[2] = 1'b0;
    expect_grant(6'd2, 1);
    wait_grant("t2_first");
    check("t2_pending", 64'(pending), 64'h24);
    do_ack("t2_first");
    expect_grant(6'd5, HO);
    wait_grant("t2_second");
    do_ack("t2_second");
    repeat (3) step();

    // Level line 7 held high through the ack: re-granted HO+1 after the ack.
    mode[7] = 1'b0;
    line[7] = 1'b1;
    expect_grant(6'd7, 1);
    wait_grant("t3_first");
    do_ack("t3_first");
    expect_grant(6'd7, HO);
    wait_grant("t3_regrant");
    do_ack("t3_regrant");
    line[7] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t3_no_regrant", 64'(active), 64'd0);
      step();
    end
    mode[7] = 1'b1;

    // New edge on line 4 in the ack cycle of line 4.
    line[4] = 1'b1;
    step();
    line[4] = 1'b0;
    expect_grant(6'd4, 1);
    wait_grant("t4_first");
    line[4] = 1'b1;
    do_ack("t4");
    line[4] = 1'b0;
    check("t4_pend4_kept", 64'(pending[4]), 64'd1);
    expect_grant(6'd4, HO);
    wait_grant("t4_regrant");
    do_ack("t4_regrant");
    repeat (3) step();

    // Synchronous reset during REQ of line 9; line stays high across it.
    line[9] = 1'b1;
    step();
    expect_grant(6'd9, 1);
    wait_grant("t5");
    sync_rst = 1'b1;
    step();
    sync_rst = 1'b0;
    check("t5_active", 64'(active),  64'd0);
    check("t5_pending", 64'(pending), 64'd0);
    check("t5_num",    64'(num),     64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5_no_edge", 64'({active, pending}), 64'd0);
    end
    line[9] = 1'b0;
    step();

    // Disabled line 1 pulsing: nothing pending, nothing granted.
    en[1]   = 1'b0;
    line[1] = 1'b1;
    step();
    line[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t6_disabled", 64'({active, pending[1]}), 64'd0);
      step();
    end

    // Enable plus edge on line 1 during REQ of line 6: grant stays on 6.
    line[6] = 1'b1;
    step();
    line[6] = 1'b0;
    expect_grant(6'd6, 1);
    wait_grant("t6_line6");
    en[1]   = 1'b1;
    line[1] = 1'b1;
    step();
    line[1] = 1'b0;
    check("t6_num_stable",    64'(num),        64'd6);
    check("t6_active_stable", 64'(active),     64'd1);
    check("t6_pend1",         64'(pending[1]), 64'd1);
    do_ack("t6_line6");
    expect_grant(6'd1, HO);
    wait_grant("t6_line1");
    do_ack("t6_line1");
    repeat (3) step();

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
